// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, special register IDs and datapath width.
package y86_pkg;

    localparam int WORD_W = 64;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_CMOVXX = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] REG_RSP  = 4'h4;
    localparam logic [3:0] REG_NONE = 4'hF;

endpackage

// File: rtl/decode_regfile_read_mux.sv
// One register-file read port: picks one of the 15 registers by ID, ID 15 reads as zero.
module regfile_read_mux
    import y86_pkg::*;
#(
    parameter int W = 64
) (
    input  logic [3:0]          id,
    input  logic [14:0][W-1:0]  regs,
    output logic [W-1:0]        val
);

    always_comb begin
        val = '0;
        if (id != REG_NONE) begin
            val = regs[id];
        end
    end

endmodule

// File: rtl/decode.sv
// Y86-64 decode stage: picks srcA/srcB from icode/rA/rB, reads them and registers valA/valB.
module decode #(
    parameter int WORD_W = y86_pkg::WORD_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        icode,
    input  logic [3:0]        rA,
    input  logic [3:0]        rB,
    input  logic [WORD_W-1:0] reg_mem0,
    input  logic [WORD_W-1:0] reg_mem1,
    input  logic [WORD_W-1:0] reg_mem2,
    input  logic [WORD_W-1:0] reg_mem3,
    input  logic [WORD_W-1:0] reg_mem4,
    input  logic [WORD_W-1:0] reg_mem5,
    input  logic [WORD_W-1:0] reg_mem6,
    input  logic [WORD_W-1:0] reg_mem7,
    input  logic [WORD_W-1:0] reg_mem8,
    input  logic [WORD_W-1:0] reg_mem9,
    input  logic [WORD_W-1:0] reg_mem10,
    input  logic [WORD_W-1:0] reg_mem11,
    input  logic [WORD_W-1:0] reg_mem12,
    input  logic [WORD_W-1:0] reg_mem13,
    input  logic [WORD_W-1:0] reg_mem14,
    output logic [WORD_W-1:0] valA,
    output logic [WORD_W-1:0] valB
);

    import y86_pkg::*;

    function automatic logic [3:0] sel_src_a(input logic [3:0] ic, input logic [3:0] ra);
        case (ic)
            I_CMOVXX, I_RMMOVQ, I_OPQ, I_PUSHQ: sel_src_a = ra;
            I_RET, I_POPQ:                      sel_src_a = REG_RSP;
            default:                            sel_src_a = REG_NONE;
        endcase
    endfunction

    function automatic logic [3:0] sel_src_b(input logic [3:0] ic, input logic [3:0] rb);
        case (ic)
            I_RMMOVQ, I_MRMOVQ, I_OPQ:         sel_src_b = rb;
            I_CALL, I_RET, I_PUSHQ, I_POPQ:    sel_src_b = REG_RSP;
            default:                           sel_src_b = REG_NONE;
        endcase
    endfunction

    logic [3:0]              src_a;
    logic [3:0]              src_b;
    logic [14:0][WORD_W-1:0] regs;
    logic [WORD_W-1:0]       rd_a;
    logic [WORD_W-1:0]       rd_b;

    always_comb begin
        src_a = sel_src_a(icode, rA);
        src_b = sel_src_b(icode, rB);
    end

    // Index n of the packed view is register n.
    assign regs = {reg_mem14, reg_mem13, reg_mem12, reg_mem11, reg_mem10,
                   reg_mem9,  reg_mem8,  reg_mem7,  reg_mem6,  reg_mem5,
                   reg_mem4,  reg_mem3,  reg_mem2,  reg_mem1,  reg_mem0};

    regfile_read_mux #(.W(WORD_W)) u_read_a (
        .id   (src_a),
        .regs (regs),
        .val  (rd_a)
    );

    regfile_read_mux #(.W(WORD_W)) u_read_b (
        .id   (src_b),
        .regs (regs),
        .val  (rd_b)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valA <= '0;
            valB <= '0;
        end else begin
            valA <= rd_a;
            valB <= rd_b;
        end
    end

endmodule

// File: tb/tb_decode.sv
// Directed and randomised checks of the decode stage against a scoreboard of {valA, valB} pairs.
module tb_decode;

    localparam int W = 64;

    logic         clk;
    logic         rst_n;
    logic [3:0]   icode;
    logic [3:0]   ra;
    logic [3:0]   rb;
    logic [W-1:0] rm [15];
    logic [W-1:0] val_a;
    logic [W-1:0] val_b;

    logic [2*W-1:0] exp_q [$];
    logic [2*W-1:0] exp_pair;
    logic [2*W-1:0] last_pair;
    int n_checks;
    int n_fail;

    decode #(.WORD_W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .icode     (icode),
        .rA        (ra),
        .rB        (rb),
        .reg_mem0  (rm[0]),
        .reg_mem1  (rm[1]),
        .reg_mem2  (rm[2]),
        .reg_mem3  (rm[3]),
        .reg_mem4  (rm[4]),
        .reg_mem5  (rm[5]),
        .reg_mem6  (rm[6]),
        .reg_mem7  (rm[7]),
        .reg_mem8  (rm[8]),
        .reg_mem9  (rm[9]),
        .reg_mem10 (rm[10]),
        .reg_mem11 (rm[11]),
        .reg_mem12 (rm[12]),
        .reg_mem13 (rm[13]),
        .reg_mem14 (rm[14]),
        .valA      (val_a),
        .valB      (val_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent reference: which operand slots each instruction reads.
    function automatic logic [W-1:0] reg_val(input logic [3:0] id);
        if (id == 4'hF) return '0;
        return rm[id];
    endfunction

    function automatic logic [2*W-1:0] model(input logic [3:0] ic, input logic [3:0] a, input logic [3:0] b);
        logic [W-1:0] ea;
        logic [W-1:0] eb;
        ea = '0;
        eb = '0;
        if (ic == 4'h2 || ic == 4'h4 || ic == 4'h6 || ic == 4'hA) ea = reg_val(a);
        if (ic == 4'h9 || ic == 4'hB) ea = rm[4];
        if (ic == 4'h4 || ic == 4'h5 || ic == 4'h6) eb = reg_val(b);
        if (ic == 4'h8 || ic == 4'h9 || ic == 4'hA || ic == 4'hB) eb = rm[4];
        return {ea, eb};
    endfunction

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
        n_checks++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, want);
        end
    endtask

    // Drive at the falling edge, let the rising edge capture, compare 1 time unit later.
    task automatic step(input string tag, input logic rst, input logic [3:0] ic,
                        input logic [3:0] a, input logic [3:0] b,
                        input logic [W-1:0] ea, input logic [W-1:0] eb);
        @(negedge clk);
        rst_n = rst;
        icode = ic;
        ra    = a;
        rb    = b;
        exp_q.push_back({ea, eb});
        @(posedge clk);
        #1;
        n_checks++;
        assert (exp_q.size() > 0) else begin
            n_fail++;
            $error("FAIL %s_queue: observed empty expected entry", tag);
        end
        if (exp_q.size() > 0) begin
            exp_pair  = exp_q.pop_front();
            last_pair = exp_pair;
            check({tag, "_valA"}, val_a, exp_pair[2*W-1:W]);
            check({tag, "_valB"}, val_b, exp_pair[W-1:0]);
        end
    endtask

    initial begin
        logic [3:0]     ric;
        logic [3:0]     rra;
        logic [3:0]     rrb;
        logic [2*W-1:0] mp;
        n_checks = 0;
        n_fail   = 0;
        rst_n = 1'b0;
        icode = 4'h6;
        ra    = 4'h1;
        rb    = 4'h2;
        rm[0] = 105; rm[1] = 53;  rm[2] = 62;   rm[3] = 217;  rm[4] = 43;
        rm[5] = 242; rm[6] = 87;  rm[7] = 26;   rm[8] = 132;  rm[9] = 230;
        rm[10] = 105; rm[11] = 53; rm[12] = 62; rm[13] = 217; rm[14] = 43;

        step("reset",     1'b0, 4'h6, 4'h1, 4'h2, 0,   0);
        step("cmovxx",    1'b1, 4'h2, 4'h0, 4'h2, 105, 0);
        step("mrmovq",    1'b1, 4'h5, 4'h1, 4'h6, 0,   87);
        step("rmmovq",    1'b1, 4'h4, 4'h4, 4'h3, 43,  217);
        step("call",      1'b1, 4'h8, 4'h7, 4'h6, 0,   43);
        step("ret",       1'b1, 4'h9, 4'h4, 4'hA, 43,  43);
        step("pushq",     1'b1, 4'hA, 4'h9, 4'hC, 230, 43);
        step("opq",       1'b1, 4'h6, 4'h6, 4'h9, 87,  230);
        step("opq_nonea", 1'b1, 4'h6, 4'hF, 4'hE, 0,   43);
        step("irmovq",    1'b1, 4'h3, 4'hF, 4'h2, 0,   0);
        step("icode_e",   1'b1, 4'hE, 4'h3, 4'h5, 0,   0);
        step("popq",      1'b1, 4'hB, 4'h8, 4'h8, 43,  43);
        step("opq_r14",   1'b1, 4'h6, 4'hE, 4'hD, 43,  217);

        // Between edges, new inputs must not reach the outputs.
        @(negedge clk);
        icode = 4'h6;
        ra    = 4'h5;
        rb    = 4'h8;
        rm[13] = 999;
        #1;
        check("hold_valA", val_a, last_pair[2*W-1:W]);
        check("hold_valB", val_b, last_pair[W-1:0]);
        rm[13] = 217;

        step("pre_rst",   1'b1, 4'h6, 4'h5, 4'h8, 242, 132);
        step("mid_rst",   1'b0, 4'h6, 4'h5, 4'h8, 0,   0);
        step("post_rst",  1'b1, 4'hA, 4'h3, 4'h0, 217, 43);

        for (int i = 0; i < 24; i++) begin
            ric = 4'($urandom_range(0, 15));
            rra = 4'($urandom_range(0, 15));
            rrb = 4'($urandom_range(0, 15));
            for (int j = 0; j < 15; j++) rm[j] = {$urandom, $urandom};
            mp = model(ric, rra, rrb);
            step("rand", 1'b1, ric, rra, rrb, mp[2*W-1:W], mp[W-1:0]);
        end

        n_checks++;
        assert (exp_q.size() == 0) else begin
            n_fail++;
            $error("FAIL queue_drain: observed %0d entries expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
